async_sram_ctrl: RTL and testbench

Two-port arbitrating controller for an external asynchronous SRAM driven through the async SRAM PHY. Accepts single-beat read/write requests from two requesters, arbitrates round-robin, and sequences the PHY's ctrl_* signals with the required setup, WE pulse, hold and bus-turnaround cycles. Returns read data or a write acknowledge to the originating port. Timing assumes the PHY registers addr/oe_n/byte_n one cycle, and passes dq combinationally.

---
 rtl/async_sram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_async_sram_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_sram_ctrl.sv
// Two-port round-robin controller for an asynchronous SRAM behind a registering PHY.
// Single outstanding access; sequences read, write-strobe and read-to-write turnaround cycles.
module async_sram_ctrl #(
  parameter int W_ADDR    = 18,
  parameter int W_DATA    = 16,
  parameter int READ_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [W_ADDR-1:0]     req0_addr,
  input  logic [W_DATA-1:0]     req0_wdata,
  input  logic [W_DATA/8-1:0]   req0_wstrb,
  output logic                  resp0_valid,
  output logic [W_DATA-1:0]     resp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [W_ADDR-1:0]     req1_addr,
  input  logic [W_DATA-1:0]     req1_wdata,
  input  logic [W_DATA/8-1:0]   req1_wstrb,
  output logic                  resp1_valid,
  output logic [W_DATA-1:0]     resp1_rdata,
  output logic [W_ADDR-1:0]     ctrl_addr,
  output logic [W_DATA-1:0]     ctrl_dq_out,
  output logic [W_DATA-1:0]     ctrl_dq_oe,
  input  logic [W_DATA-1:0]     ctrl_dq_in,
  output logic                  ctrl_ce_n,
  output logic                  ctrl_we_n,
  output logic                  ctrl_oe_n,
  output logic [W_DATA/8-1:0]   ctrl_byte_n
);

  localparam int W_STRB = W_DATA / 8;
  localparam logic [2:0] RD_LAST = 3'(READ_WAIT);

  typedef enum logic [2:0] {IDLE, TURN, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_e;

  state_e              state_q, state_d;
  logic [W_ADDR-1:0]   addr_q, addr_d;
  logic [W_DATA-1:0]   wdata_q, wdata_d;
  logic [W_STRB-1:0]   wstrb_q, wstrb_d;
  logic                port_q, port_d;
  logic                pri_q, pri_d;
  logic                prev_rd_q, prev_rd_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                resp0_valid_q, resp0_valid_d;
  logic                resp1_valid_q, resp1_valid_d;
  logic [W_DATA-1:0]   rdata0_q, rdata0_d;
  logic [W_DATA-1:0]   rdata1_q, rdata1_d;
  logic                grant;
  logic                wr_drive;

  // Address and write data are driven straight from the capture registers,
  // so they naturally hold their last value while idle.
  assign ctrl_addr   = addr_q;
  assign ctrl_dq_out = wdata_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    port_d        = port_q;
    pri_d         = pri_q;
    prev_rd_d     = prev_rd_q;
    cnt_d         = cnt_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    wr_drive      = 1'b0;
    ctrl_ce_n     = 1'b1;
    ctrl_we_n     = 1'b1;
    ctrl_oe_n     = 1'b1;
    ctrl_byte_n   = '1;
    ctrl_dq_oe    = '0;
    // pri_q names the port that wins a tie; a lone requester always wins.
    grant = (req0_valid && req1_valid) ? pri_q : req1_valid;

    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = !grant;
          req1_ready = grant;
          port_d     = grant;
          pri_d      = !grant;
          addr_d     = grant ? req1_addr : req0_addr;
          cnt_d      = '0;
          if (grant ? req1_write : req0_write) begin
            wdata_d = grant ? req1_wdata : req0_wdata;
            wstrb_d = grant ? req1_wstrb : req0_wstrb;
            state_d = prev_rd_q ? TURN : WR_SETUP;
          end else begin
            state_d = RD;
          end
        end
      end
      TURN: state_d = WR_SETUP;
      RD: begin
        ctrl_ce_n   = 1'b0;
        ctrl_oe_n   = 1'b0;
        ctrl_byte_n = '0;
        if (cnt_q == RD_LAST) begin
          state_d   = IDLE;
          prev_rd_d = 1'b1;
          if (port_q) begin
            rdata1_d      = ctrl_dq_in;
            resp1_valid_d = 1'b1;
          end else begin
            rdata0_d      = ctrl_dq_in;
            resp0_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR_SETUP: begin
        wr_drive = 1'b1;
        state_d  = WR_PULSE;
      end
      WR_PULSE: begin
        wr_drive  = 1'b1;
        ctrl_we_n = 1'b0;
        state_d   = WR_HOLD;
      end
      WR_HOLD: begin
        wr_drive      = 1'b1;
        state_d       = IDLE;
        prev_rd_d     = 1'b0;
        resp0_valid_d = !port_q;
        resp1_valid_d = port_q;
      end
      default: state_d = IDLE;
    endcase

    if (wr_drive) begin
      ctrl_ce_n   = 1'b0;
      ctrl_byte_n = ~wstrb_q;
      ctrl_dq_oe  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      port_q        <= 1'b0;
      pri_q         <= 1'b0;
      prev_rd_q     <= 1'b0;
      cnt_q         <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      port_q        <= port_d;
      pri_q         <= pri_d;
      prev_rd_q     <= prev_rd_d;
      cnt_q         <= cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Directed bench for async_sram_ctrl; instance 0 uses READ_WAIT=1, instances 1/2 use 0/3.
module tb_async_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [17:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0, ctrl_dq_in = '0;
  logic [1:0]  req0_wstrb = '0, req1_wstrb = '0;

  logic        req0_ready [3];
  logic        req1_ready [3];
  logic        resp0_valid[3];
  logic        resp1_valid[3];
  logic [15:0] resp0_rdata[3];
  logic [15:0] resp1_rdata[3];
  logic [17:0] ctrl_addr  [3];
  logic [15:0] ctrl_dq_out[3];
  logic [15:0] ctrl_dq_oe [3];
  logic        ctrl_ce_n  [3];
  logic        ctrl_we_n  [3];
  logic        ctrl_oe_n  [3];
  logic [1:0]  ctrl_byte_n[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RWV = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    async_sram_ctrl #(.W_ADDR(18), .W_DATA(16), .READ_WAIT(RWV)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready[g]), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
      .resp0_valid(resp0_valid[g]), .resp0_rdata(resp0_rdata[g]),
      .req1_valid(req1_valid), .req1_ready(req1_ready[g]), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
      .resp1_valid(resp1_valid[g]), .resp1_rdata(resp1_rdata[g]),
      .ctrl_addr(ctrl_addr[g]), .ctrl_dq_out(ctrl_dq_out[g]), .ctrl_dq_oe(ctrl_dq_oe[g]),
      .ctrl_dq_in(ctrl_dq_in), .ctrl_ce_n(ctrl_ce_n[g]), .ctrl_we_n(ctrl_we_n[g]),
      .ctrl_oe_n(ctrl_oe_n[g]), .ctrl_byte_n(ctrl_byte_n[g])
    );
  end

  // {ce_n, we_n, oe_n, byte_n, dq_oe} of instance 0
  function automatic logic [20:0] pins();
    return {ctrl_ce_n[0], ctrl_we_n[0], ctrl_oe_n[0], ctrl_byte_n[0], ctrl_dq_oe[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic p, input logic wr, input logic [17:0] a,
                           input logic [15:0] d, input logic [1:0] s);
    if (p) begin
      req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d; req1_wstrb = s;
    end else begin
      req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d; req0_wstrb = s;
    end
  endtask

  task automatic apply_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; ctrl_dq_in = '0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    drive_req(0, 0, 18'h1, 16'h0, 2'b00);
    drive_req(1, 0, 18'h2, 16'h0, 2'b00);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({req0_ready[0], req1_ready[0]} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready[0], req1_ready[0]});
    end
    checks++;
    if (pins() !== {3'b111, 2'b11, 16'h0}) begin
      errors++; $display("FAIL reset_pins got %h exp %h", pins(), {3'b111, 2'b11, 16'h0});
    end
    checks++;
    if ({ctrl_addr[0], ctrl_dq_out[0]} !== 34'h0) begin
      errors++; $display("FAIL reset_addr_dq got %h/%h exp 0/0", ctrl_addr[0], ctrl_dq_out[0]);
    end
    checks++;
    if ({resp0_valid[0], resp1_valid[0], resp0_rdata[0], resp1_rdata[0]} !== 34'h0) begin
      errors++; $display("FAIL reset_resp got %b%b %h %h exp 00 0 0",
                         resp0_valid[0], resp1_valid[0], resp0_rdata[0], resp1_rdata[0]);
    end
    tick();
    req0_valid = 0; req1_valid = 0; rst = 0;
  endtask

  task automatic test_read();
    apply_reset();
    drive_req(0, 0, 18'h00123, 16'hDEAD, 2'b10);
    @(negedge clk);
    checks++;
    if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL rd_accept got %b exp 10", {req0_ready[0], req1_ready[0]});
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req0_valid = 0;
      ctrl_dq_in = (c == 2) ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      if (c <= 2) begin
        checks++;
        if (pins() !== {3'b010, 2'b00, 16'h0} || ctrl_addr[0] !== 18'h00123) begin
          errors++; $display("FAIL rd_pins c%0d got %h addr %h exp %h addr 00123",
                             c, pins(), ctrl_addr[0], {3'b010, 2'b00, 16'h0});
        end
      end
      checks++;
      if (resp0_valid[0] !== (c == 3)) begin
        errors++; $display("FAIL rd_resp_valid c%0d got %b exp %b", c, resp0_valid[0], c == 3);
      end
      if (c >= 3) begin
        checks++;
        if (resp0_rdata[0] !== 16'hBEEF) begin
          errors++; $display("FAIL rd_rdata c%0d got %h exp beef", c, resp0_rdata[0]);
        end
      end
    end
  endtask

  task automatic test_write();
    apply_reset();
    drive_req(1, 1, 18'h3FFFF, 16'hA55A, 2'b01);
    @(negedge clk);
    checks++;
    if ({req0_ready[0], req1_ready[0]} !== 2'b01) begin
      errors++; $display("FAIL wr_accept got %b exp 01", {req0_ready[0], req1_ready[0]});
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) req1_valid = 0;
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (pins() !== {1'b0, c != 2, 1'b1, 2'b10, 16'hFFFF} ||
            ctrl_addr[0] !== 18'h3FFFF || ctrl_dq_out[0] !== 16'hA55A) begin
          errors++; $display("FAIL wr_pins c%0d got %h addr %h dq %h exp %h addr 3ffff dq a55a",
                             c, pins(), ctrl_addr[0], ctrl_dq_out[0],
                             {1'b0, c != 2, 1'b1, 2'b10, 16'hFFFF});
        end
      end
      checks++;
      if ({resp0_valid[0], resp1_valid[0]} !== {1'b0, c == 4}) begin
        errors++; $display("FAIL wr_resp c%0d got %b%b exp 0%b",
                           c, resp0_valid[0], resp1_valid[0], c == 4);
      end
      if (c == 4) begin
        checks++;
        if (pins() !== {3'b111, 2'b11, 16'h0} || resp1_rdata[0] !== 16'h0 ||
            ctrl_addr[0] !== 18'h3FFFF || ctrl_dq_out[0] !== 16'hA55A) begin
          errors++; $display("FAIL wr_idle got %h rdata %h addr %h dq %h",
                             pins(), resp1_rdata[0], ctrl_addr[0], ctrl_dq_out[0]);
        end
      end
    end
  endtask

  task automatic test_wstrb0();
    apply_reset();
    drive_req(0, 1, 18'h00ABC, 16'h1234, 2'b00);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req0_valid = 0;
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (pins() !== {1'b0, c != 2, 1'b1, 2'b11, 16'hFFFF}) begin
          errors++; $display("FAIL wstrb0_pins c%0d got %h exp %h",
                             c, pins(), {1'b0, c != 2, 1'b1, 2'b11, 16'hFFFF});
        end
      end
      checks++;
      if (resp0_valid[0] !== (c == 4)) begin
        errors++; $display("FAIL wstrb0_resp c%0d got %b exp %b", c, resp0_valid[0], c == 4);
      end
    end
  endtask

  task automatic test_turnaround();
    logic [20:0] exp_pins;
    apply_reset();
    drive_req(0, 0, 18'h00055, 16'h0, 2'b00);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1 || c == 4) req0_valid = 0;
      if (c == 3) drive_req(0, 1, 18'h00066, 16'h7777, 2'b11);
      ctrl_dq_in = (c == 2) ? 16'h1234 : 16'h0000;
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (req0_ready[0] !== 1'b1) begin
          errors++; $display("FAIL turn_accept got %b exp 1", req0_ready[0]);
        end
      end
      if (c >= 4 && c <= 7) begin
        case (c)
          4:       exp_pins = {3'b111, 2'b11, 16'h0000};
          6:       exp_pins = {3'b001, 2'b00, 16'hFFFF};
          default: exp_pins = {3'b011, 2'b00, 16'hFFFF};
        endcase
        checks++;
        if (pins() !== exp_pins || ctrl_addr[0] !== 18'h00066) begin
          errors++; $display("FAIL turn_pins c%0d got %h addr %h exp %h addr 00066",
                             c, pins(), ctrl_addr[0], exp_pins);
        end
      end
      checks++;
      if (resp0_valid[0] !== (c == 3 || c == 8)) begin
        errors++; $display("FAIL turn_resp c%0d got %b exp %b", c, resp0_valid[0], c == 3 || c == 8);
      end
      if (c == 3 || c == 8) begin
        checks++;
        if (resp0_rdata[0] !== 16'h1234) begin
          errors++; $display("FAIL turn_rdata c%0d got %h exp 1234", c, resp0_rdata[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int gcyc[$];
    int gport[$];
    int allg[$];
    int nresp = 0;
    int gc, gp;
    apply_reset();
    drive_req(0, 0, 18'h00010, 16'h0, 2'b00);
    drive_req(1, 0, 18'h00020, 16'h0, 2'b00);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) tick();
      if (c == 12) begin req0_valid = 0; req1_valid = 0; end
      ctrl_dq_in = 16'h1000 + 16'(c);
      @(negedge clk);
      checks++;
      if (req0_ready[0] && req1_ready[0]) begin
        errors++; $display("FAIL b2b_dual_ready c%0d got 11 exp not both", c);
      end
      if (req0_ready[0]) begin gcyc.push_back(c); gport.push_back(0); allg.push_back(0); end
      if (req1_ready[0]) begin gcyc.push_back(c); gport.push_back(1); allg.push_back(1); end
      if (resp0_valid[0] || resp1_valid[0]) begin
        nresp++;
        checks++;
        if (gcyc.size() == 0) begin
          errors++; $display("FAIL b2b_resp_unexpected c%0d got resp exp none", c);
        end else begin
          gc = gcyc.pop_front();
          gp = gport.pop_front();
          if ({resp0_valid[0], resp1_valid[0]} !== ((gp == 1) ? 2'b01 : 2'b10) || c != gc + 3 ||
              ((gp == 1) ? resp1_rdata[0] : resp0_rdata[0]) !== 16'h1000 + 16'(gc + 2)) begin
            errors++; $display("FAIL b2b_resp c%0d got v%b%b r0 %h r1 %h exp port %0d rdata %h",
                               c, resp0_valid[0], resp1_valid[0], resp0_rdata[0], resp1_rdata[0],
                               gp, 16'h1000 + 16'(gc + 2));
          end
        end
      end
    end
    checks++;
    if (allg.size() != 4 || nresp != 4 || gcyc.size() != 0) begin
      errors++; $display("FAIL b2b_counts got grants %0d resps %0d exp 4 4", allg.size(), nresp);
    end
    foreach (allg[i]) begin
      checks++;
      if (allg[i] != i % 2) begin
        errors++; $display("FAIL b2b_order grant %0d got port %0d exp %0d", i, allg[i], i % 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_req(0, 1, 18'h00001, 16'h0002, 2'b11);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req0_valid = 0;
      if (c == 2) rst = 1;
      if (c == 3) begin
        rst = 0;
        drive_req(0, 0, 18'h00011, 16'h0, 2'b00);
        drive_req(1, 0, 18'h00022, 16'h0, 2'b00);
      end
      if (c == 4) begin req0_valid = 0; req1_valid = 0; end
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (pins() !== {3'b001, 2'b00, 16'hFFFF}) begin
          errors++; $display("FAIL rstmid_pulse got %h exp %h", pins(), {3'b001, 2'b00, 16'hFFFF});
        end
      end
      if (c == 3) begin
        checks++;
        if (pins() !== {3'b111, 2'b11, 16'h0}) begin
          errors++; $display("FAIL rstmid_idle got %h exp %h", pins(), {3'b111, 2'b11, 16'h0});
        end
        checks++;
        if ({req0_ready[0], req1_ready[0]} !== 2'b10) begin
          errors++; $display("FAIL rstmid_grant got %b exp 10", {req0_ready[0], req1_ready[0]});
        end
      end
      if (c == 4) begin
        checks++;
        if (ctrl_oe_n[0] !== 1'b0 || ctrl_addr[0] !== 18'h00011) begin
          errors++; $display("FAIL rstmid_rd got oe_n %b addr %h exp 0 00011", ctrl_oe_n[0], ctrl_addr[0]);
        end
      end
      if (c >= 3) begin
        checks++;
        if ({resp0_valid[0], resp1_valid[0]} !== 2'b00) begin
          errors++; $display("FAIL rstmid_noresp c%0d got %b%b exp 00", c, resp0_valid[0], resp1_valid[0]);
        end
      end
    end
  endtask

  task automatic test_read_wait();
    int expc[3] = '{3, 2, 5};
    apply_reset();
    drive_req(0, 0, 18'h00007, 16'h0, 2'b00);
    ctrl_dq_in = 16'h2000;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) req0_valid = 0;
      ctrl_dq_in = 16'h2000 + 16'(c);
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (resp0_valid[g] !== (c == expc[g])) begin
          errors++; $display("FAIL rw_resp inst%0d c%0d got %b exp %b", g, c, resp0_valid[g], c == expc[g]);
        end
        if (c == expc[g]) begin
          checks++;
          if (resp0_rdata[g] !== 16'h2000 + 16'(expc[g] - 1)) begin
            errors++; $display("FAIL rw_rdata inst%0d got %h exp %h",
                               g, resp0_rdata[g], 16'h2000 + 16'(expc[g] - 1));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wstrb0();
    test_turnaround();
    test_back_to_back();
    test_reset_mid();
    test_read_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
